icache_2way: RTL and testbench

//  2-way set-associative instruction cache. Sits directly upstream of the IF stage.
//  - IF drives lookup address and read enable; the cache returns hit and instruction

---
 rtl/icache_2way_if.sv | 26 ++
 rtl/icache_2way.sv | 119 +++++++++++
 tb/tb_icache_2way.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_2way_if.sv
// rtl/icache_2way_if.sv - lookup, fill, flush and counter signals between IF stage and icache_2way
interface icache_2way_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              rd_en_i;
    logic [ADDR_W-1:0] raddr_i;
    logic              hit_o;
    logic [31:0]       inst_o;
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [31:0]       winst_i;
    logic              flush_i;
    logic [CNT_W-1:0]  hit_cnt_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    modport master (
        output rd_en_i, raddr_i, we_i, waddr_i, winst_i, flush_i,
        input  hit_o, inst_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        input  rd_en_i, raddr_i, we_i, waddr_i, winst_i, flush_i,
        output hit_o, inst_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/icache_2way.sv
// rtl/icache_2way.sv - 2-way set-associative instruction cache with combinational lookup and LRU fill
module icache_2way #(
    parameter int INDEX_W = 7,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32
) (
    input logic          clk,
    input logic          rst,
    icache_2way_if.slave bus
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    // Tag/data storage carries no reset; valid and LRU bits gate every use of it.
    logic [TAG_W-1:0] tag_q  [SETS][2];
    logic [31:0]      data_q [SETS][2];
    logic [1:0]       valid_q [SETS];
    logic [SETS-1:0]  lru_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic [INDEX_W-1:0] r_idx;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         r_way_hit;
    logic [1:0]         w_way_hit;
    logic               fill_en;
    logic               bypass;
    logic               hit;
    logic [31:0]        inst;
    logic               tgt;
    logic               unused_addr_bits;

    assign r_idx = bus.raddr_i[INDEX_W+1:2];
    assign r_tag = bus.raddr_i[ADDR_W-1:INDEX_W+2];
    assign w_idx = bus.waddr_i[INDEX_W+1:2];
    assign w_tag = bus.waddr_i[ADDR_W-1:INDEX_W+2];
    assign unused_addr_bits = ^{bus.raddr_i[1:0], bus.waddr_i[1:0]};

    // Tag compare for the lookup port and the fill port, bypass, output mux and fill way choice.
    always_comb begin
        r_way_hit[0] = valid_q[r_idx][0] && (tag_q[r_idx][0] == r_tag);
        r_way_hit[1] = valid_q[r_idx][1] && (tag_q[r_idx][1] == r_tag);
        w_way_hit[0] = valid_q[w_idx][0] && (tag_q[w_idx][0] == w_tag);
        w_way_hit[1] = valid_q[w_idx][1] && (tag_q[w_idx][1] == w_tag);

        fill_en = bus.we_i && !bus.flush_i;
        bypass  = fill_en && (r_idx == w_idx) && (r_tag == w_tag);
        hit     = !bus.flush_i && (bypass || (|r_way_hit));

        inst = 32'h0;
        if (!bus.flush_i) begin
            if (bypass)
                inst = bus.winst_i;
            else if (r_way_hit[0])
                inst = data_q[r_idx][0];
            else if (r_way_hit[1])
                inst = data_q[r_idx][1];
        end

        // Overwrite in place first so a set never holds the same tag twice.
        if (w_way_hit[0])
            tgt = 1'b0;
        else if (w_way_hit[1])
            tgt = 1'b1;
        else if (!valid_q[w_idx][0])
            tgt = 1'b0;
        else if (!valid_q[w_idx][1])
            tgt = 1'b1;
        else
            tgt = lru_q[w_idx];
    end

    assign bus.hit_o      = hit;
    assign bus.inst_o     = inst;
    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;

    // Valid/LRU state: reset and flush clear everything; a fill's LRU update overrides a read's.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            for (int s = 0; s < SETS; s++)
                valid_q[s] <= 2'b00;
            lru_q <= '0;
        end else begin
            if (bus.rd_en_i && (|r_way_hit))
                lru_q[r_idx] <= r_way_hit[0];
            if (fill_en) begin
                valid_q[w_idx][tgt] <= 1'b1;
                lru_q[w_idx]        <= ~tgt;
            end
        end
    end

    // Tag/data write for a fill; a fill coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_q[w_idx][tgt]  <= w_tag;
            data_q[w_idx][tgt] <= bus.winst_i;
        end
    end

    // Saturating hit/miss counters, advanced on every lookup cycle including flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (bus.rd_en_i) begin
            if (hit) begin
                if (hit_cnt_q != '1)
                    hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != '1)
                    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_icache_2way.sv
// tb/tb_icache_2way.sv - scoreboard bench for icache_2way against a recency-list cache model
module tb_icache_2way;
    localparam int SETS = 128;

    typedef struct {
        logic        hit;
        logic [31:0] inst;
        logic [31:0] hc;
        logic [31:0] mc;
        logic [31:0] hc4;
        logic [31:0] mc4;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_2way_if #(.ADDR_W(32), .CNT_W(32)) bus ();
    icache_2way_if #(.ADDR_W(32), .CNT_W(4))  bus4 ();

    icache_2way #(.INDEX_W(7), .ADDR_W(32), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    icache_2way #(.INDEX_W(7), .ADDR_W(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.rd_en_i = bus.rd_en_i;
    assign bus4.raddr_i = bus.raddr_i;
    assign bus4.we_i    = bus.we_i;
    assign bus4.waddr_i = bus.waddr_i;
    assign bus4.winst_i = bus.winst_i;
    assign bus4.flush_i = bus.flush_i;

    // Reference model: per set, a recency list of resident tags (slot 0 = most recent).
    int          m_n    [SETS];
    logic [31:0] m_tag  [SETS][2];
    logic [31:0] m_data [SETS][2];
    longint      m_hc, m_mc;
    int          m_hc4, m_mc4;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 0;

    function automatic int find(int s, logic [31:0] t);
        for (int p = 0; p < m_n[s]; p++)
            if (m_tag[s][p] == t) return p;
        return -1;
    endfunction

    function automatic void to_front(int s, int p);
        logic [31:0] t, d;
        if (p == 1) begin
            t = m_tag[s][0];  d = m_data[s][0];
            m_tag[s][0] = m_tag[s][1];  m_data[s][0] = m_data[s][1];
            m_tag[s][1] = t;  m_data[s][1] = d;
        end
    endfunction

    function automatic void clear_model();
        for (int s = 0; s < SETS; s++) m_n[s] = 0;
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic cyc(bit r, bit rd, logic [31:0] ra, bit we, logic [31:0] wa, logic [31:0] wd, bit fl);
        exp_t e;
        int ri, wi, rp, fp, p;
        logic [31:0] rt, wt, victim;
        bit bypass;
        @(posedge clk);
        #1;
        rst = r;
        bus.rd_en_i = rd;  bus.raddr_i = ra;
        bus.we_i = we;     bus.waddr_i = wa;  bus.winst_i = wd;
        bus.flush_i = fl;

        ri = int'((ra / 4) % SETS);  rt = ra / 512;
        wi = int'((wa / 4) % SETS);  wt = wa / 512;
        bypass = we && !fl && (ri == wi) && (rt == wt);
        rp = find(ri, rt);
        e.hit  = !fl && (bypass || rp >= 0);
        e.inst = fl ? 32'h0 : bypass ? wd : (rp >= 0) ? m_data[ri][rp] : 32'h0;
        e.hc   = 32'(m_hc);   e.mc  = 32'(m_mc);
        e.hc4  = 32'(m_hc4);  e.mc4 = 32'(m_mc4);
        if (check_en) exp_q.push_back(e);

        if (r) begin
            clear_model();
            m_hc = 0; m_mc = 0; m_hc4 = 0; m_mc4 = 0;
            return;
        end
        if (rd) begin
            if (e.hit) begin
                if (m_hc < 64'hFFFF_FFFF) m_hc++;
                if (m_hc4 < 15) m_hc4++;
            end else begin
                if (m_mc < 64'hFFFF_FFFF) m_mc++;
                if (m_mc4 < 15) m_mc4++;
            end
        end
        if (fl) begin
            clear_model();
            return;
        end
        fp = -1;
        victim = 32'h0;
        if (we) begin
            fp = find(wi, wt);
            if (fp < 0 && m_n[wi] == 2) victim = m_tag[wi][1];
        end
        if (rd && rp >= 0) to_front(ri, rp);
        if (we) begin
            if (fp >= 0) begin
                p = find(wi, wt);
                m_data[wi][p] = wd;
                to_front(wi, p);
            end else if (m_n[wi] < 2) begin
                if (m_n[wi] == 1) begin
                    m_tag[wi][1] = m_tag[wi][0];  m_data[wi][1] = m_data[wi][0];
                end
                m_tag[wi][0] = wt;  m_data[wi][0] = wd;
                m_n[wi]++;
            end else begin
                p = find(wi, victim);
                m_tag[wi][p] = wt;  m_data[wi][p] = wd;
                to_front(wi, p);
            end
        end
    endtask

    task automatic rd(logic [31:0] a);
        cyc(0, 1, a, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic fill(logic [31:0] a, logic [31:0] d);
        cyc(0, 0, 32'h0, 1, a, d, 0);
    endtask

    // Monitor: every cycle the cache presents a response, compare it with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hit_o", 32'(bus.hit_o), 32'(e.hit));
            check("inst_o", bus.inst_o, e.inst);
            check("hit_cnt_o", bus.hit_cnt_o, e.hc);
            check("miss_cnt_o", bus.miss_cnt_o, e.mc);
            check("hit_cnt4", 32'(bus4.hit_cnt_o), e.hc4);
            check("miss_cnt4", 32'(bus4.miss_cnt_o), e.mc4);
        end
    end

    initial begin
        logic [31:0] ra, wa;
        rst = 1'b1;
        bus.rd_en_i = 0; bus.raddr_i = 0; bus.we_i = 0;
        bus.waddr_i = 0; bus.winst_i = 0; bus.flush_i = 0;
        clear_model();
        m_hc = 0; m_mc = 0; m_hc4 = 0; m_mc4 = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check_en = 1;

        rd(32'h0);
        rd(32'h4);

        fill(32'h100, 32'hDEADBEEF);
        rd(32'h100);
        rd(32'h102);

        fill(32'h000, 32'h11111111);
        fill(32'h200, 32'h22222222);
        fill(32'h400, 32'h44444444);
        rd(32'h000);
        rd(32'h200);
        rd(32'h400);
        rd(32'h200);
        fill(32'h600, 32'h66666666);
        rd(32'h400);
        rd(32'h200);
        rd(32'h600);

        cyc(0, 1, 32'h80, 1, 32'h80, 32'h13, 0);
        rd(32'h80);

        fill(32'h10, 32'hAAAA0010);
        cyc(0, 1, 32'h10, 1, 32'h20, 32'hBBBB0020, 1);
        rd(32'h10);
        rd(32'h20);

        fill(32'h100, 32'hCAFEF00D);
        for (int i = 0; i < 20; i++) rd(32'h100);
        for (int i = 0; i < 20; i++) rd(32'h3000 + 32'(i * 4));

        cyc(1, 1, 32'h300, 1, 32'h300, 32'h5A5A5A5A, 0);
        rd(32'h300);
        rd(32'h100);

        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 3)
                wa = ra ^ $urandom_range(0, 3);
            else
                wa = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), ra,
                ($urandom_range(0, 9) < 3), wa, $urandom, ($urandom_range(0, 99) < 2));
        end

        cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
